// File: rtl/alu_pkg.sv
// Shared opcode values, FSM state type and ALU_control decode for the
// chunked ALU sequencer.
package alu_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_NOR = 4'b1100;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   typedef enum logic [1:0] {IDLE, CHUNK, SETFIX, DONE} state_t;

   typedef struct packed {
      logic       A_invert;
      logic       B_invert;
      logic       cin;
      logic [1:0] operation;
   } alu_dec_t;

   function automatic alu_dec_t alu_decode(input logic [3:0] ctl);
      alu_dec_t d;
      d = '0;
      case (ctl)
         ALU_AND: d.operation = 2'b00;
         ALU_OR:  d.operation = 2'b01;
         ALU_ADD: d.operation = 2'b10;
         ALU_SUB, ALU_SLT: begin
            d.operation = 2'b10;
            d.B_invert  = 1'b1;
            d.cin       = 1'b1;
         end
         ALU_NOR: begin
            d.operation = 2'b00;
            d.A_invert  = 1'b1;
            d.B_invert  = 1'b1;
         end
         // Unknown opcodes still run as an ADD so latency matches.
         default: d.operation = 2'b10;
      endcase
      return d;
   endfunction

   function automatic logic alu_known(input logic [3:0] ctl);
      return (ctl == ALU_AND) || (ctl == ALU_OR) || (ctl == ALU_ADD) ||
             (ctl == ALU_SUB) || (ctl == ALU_NOR) || (ctl == ALU_SLT);
   endfunction

endpackage

// File: rtl/alu8.sv
// 8-bit ripple slice chain: per-bit invert, AND/OR/ADD/LESS select, and the
// carry out of every bit exposed for overflow detection by the caller.
module alu8 (
   input  logic [7:0] src1,
   input  logic [7:0] src2,
   input  logic       A_invert,
   input  logic       B_invert,
   input  logic       cin,
   input  logic       less,
   input  logic [1:0] operation,
   output logic [7:0] result,
   output logic [7:0] all_cout
);

   always_comb begin
      logic [8:0] c;
      logic       a;
      logic       b;
      c        = '0;
      c[0]     = cin;
      result   = '0;
      all_cout = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         a      = src1[i] ^ A_invert;
         b      = src2[i] ^ B_invert;
         c[i+1] = (a & b) | (a & c[i]) | (b & c[i]);
         all_cout[i] = c[i+1];
         case (operation)
            2'b00:   result[i] = a & b;
            2'b01:   result[i] = a | b;
            2'b10:   result[i] = a ^ b ^ c[i];
            default: result[i] = (i == 0) ? less : 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/alu_seq32.sv
// Multi-cycle ALU: one alu8 stepped over WIDTH/8 byte chunks with a registered
// inter-chunk carry; SLT resolved in an extra fix-up cycle.
module alu_seq32
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       ALU_control,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             cout,
   output logic             overflow
);

   localparam int unsigned NCHUNK = WIDTH / 8;
   localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

   state_t           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [3:0]       ctl_q, ctl_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             carry_q, carry_d;
   logic             wovf_q, wovf_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   alu_dec_t   dec;
   logic       known;
   logic       arith;
   logic [7:0] sl_a;
   logic [7:0] sl_b;
   logic       sl_cin;
   logic [7:0] sl_res;
   logic [7:0] sl_cout;
   logic       unused_cout;

   assign dec         = alu_decode(ctl_q);
   assign known       = alu_known(ctl_q);
   assign arith       = (dec.operation == 2'b10);
   assign sl_cin      = (idx_q == '0) ? dec.cin : carry_q;
   assign unused_cout = ^sl_cout[5:0];

   always_comb begin
      sl_a = '0;
      sl_b = '0;
      for (int unsigned k = 0; k < NCHUNK; k++) begin
         if (idx_q == k[IW-1:0]) begin
            sl_a = a_q[k*8 +: 8];
            sl_b = b_q[k*8 +: 8];
         end
      end
   end

   alu8 u_alu8 (
      .src1      (sl_a),
      .src2      (sl_b),
      .A_invert  (dec.A_invert),
      .B_invert  (dec.B_invert),
      .cin       (sl_cin),
      .less      (1'b0),
      .operation (dec.operation),
      .result    (sl_res),
      .all_cout  (sl_cout)
   );

   always_comb begin
      logic             pub;
      logic [WIDTH-1:0] pub_res;
      logic             pub_cout;
      logic             pub_ovf;
      logic             set;
      state_d  = state_q;
      idx_d    = idx_q;
      a_d      = a_q;
      b_d      = b_q;
      ctl_d    = ctl_q;
      acc_d    = acc_q;
      carry_d  = carry_q;
      wovf_d   = wovf_q;
      result_d = result_q;
      zero_d   = zero_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      pub      = 1'b0;
      pub_res  = '0;
      pub_cout = 1'b0;
      pub_ovf  = 1'b0;
      set      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = src1;
               b_d     = src2;
               ctl_d   = ALU_control;
               idx_d   = '0;
               state_d = CHUNK;
            end
         end
         CHUNK: begin
            for (int unsigned k = 0; k < NCHUNK; k++) begin
               if (idx_q == k[IW-1:0]) acc_d[k*8 +: 8] = sl_res;
            end
            carry_d = sl_cout[7];
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               idx_d  = '0;
               wovf_d = arith & (sl_cout[7] ^ sl_cout[6]);
               if (ctl_q == ALU_SLT) begin
                  state_d = SETFIX;
               end else begin
                  state_d  = DONE;
                  pub      = 1'b1;
                  pub_res  = acc_d;
                  pub_cout = arith & sl_cout[7];
                  pub_ovf  = arith & (sl_cout[7] ^ sl_cout[6]);
               end
            end
         end
         SETFIX: begin
            // Sign of the difference, corrected by signed overflow.
            set     = acc_q[WIDTH-1] ^ wovf_q;
            acc_d   = {{(WIDTH-1){1'b0}}, set};
            pub     = 1'b1;
            pub_res = acc_d;
            state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (pub) begin
         result_d = known ? pub_res : '0;
         cout_d   = known & pub_cout;
         ovf_d    = known & pub_ovf;
         zero_d   = known & (pub_res == '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         ctl_q    <= '0;
         acc_q    <= '0;
         carry_q  <= 1'b0;
         wovf_q   <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         a_q      <= a_d;
         b_q      <= b_d;
         ctl_q    <= ctl_d;
         acc_q    <= acc_d;
         carry_q  <= carry_d;
         wovf_q   <= wovf_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign result   = result_q;
   assign zero     = zero_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_seq32.sv
// Self-checking bench for alu_seq32: vector table through a scoreboard queue,
// plus ignored-start, back-to-back and mid-operation reset sequences.
module tb_alu_seq32;
   import alu_pkg::*;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic        z;
      logic        c;
      logic        o;
      int          lat;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  ALU_control = '0;
   logic [31:0] src1 = '0;
   logic [31:0] src2 = '0;
   logic        busy, done, zero, cout, overflow;
   logic [31:0] result;

   int checks = 0;
   int failures = 0;
   vec_t sb[$];
   vec_t vt[0:17];

   always #5 clk = ~clk;

   alu_seq32 #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ALU_control(ALU_control),
      .src1(src1), .src2(src2), .busy(busy), .done(done), .result(result),
      .zero(zero), .cout(cout), .overflow(overflow)
   );

   function automatic vec_t mk(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                               logic [31:0] r, logic z, logic c, logic o, int lat);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.r = r; v.z = z; v.c = c; v.o = o; v.lat = lat;
      return v;
   endfunction

   // Independent reference built from 33-bit arithmetic and signed compare.
   function automatic vec_t model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
      vec_t v;
      logic [32:0] s;
      v = mk(op, a, b, '0, 1'b0, 1'b0, 1'b0, 5);
      case (op)
         ALU_AND: v.r = a & b;
         ALU_OR:  v.r = a | b;
         ALU_NOR: v.r = ~(a | b);
         ALU_ADD: begin
            s = {1'b0, a} + {1'b0, b};
            v.r = s[31:0]; v.c = s[32];
            v.o = (a[31] == b[31]) && (v.r[31] != a[31]);
         end
         ALU_SUB: begin
            s = {1'b0, a} + {1'b0, ~b} + 33'd1;
            v.r = s[31:0]; v.c = s[32];
            v.o = (a[31] != b[31]) && (v.r[31] != a[31]);
         end
         ALU_SLT: begin
            v.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            v.lat = 6;
         end
         default: v.r = '0;
      endcase
      v.z = alu_known(op) && (v.r == '0);
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Drives one request, optionally pulsing start with junk operands while busy.
   task automatic do_op(vec_t v, bit extra);
      int   cyc;
      vec_t e;
      @(negedge clk);
      ALU_control = v.op; src1 = v.a; src2 = v.b; start = 1'b1;
      sb.push_back(v);
      @(posedge clk); #1;
      cyc = 1;
      chk("busy_after_accept", {31'b0, busy}, 32'd1);
      while (!done && cyc < 20) begin
         @(negedge clk);
         if (extra && cyc >= 1 && cyc <= 4) begin
            start = 1'b1; ALU_control = ALU_ADD;
            src1 = $urandom; src2 = $urandom;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      e = sb.pop_front();
      if (!done) begin
         failures++; checks++;
         $display("FAIL timeout: no done within %0d cycles (op %h)", cyc, e.op);
      end else begin
         chk("latency", cyc, e.lat);
         chk("result", result, e.r);
         chk("zero", {31'b0, zero}, {31'b0, e.z});
         chk("cout", {31'b0, cout}, {31'b0, e.c});
         chk("overflow", {31'b0, overflow}, {31'b0, e.o});
         @(posedge clk); #1;
         chk("done_one_cycle", {31'b0, done}, 32'd0);
         chk("idle_after_done", {31'b0, busy}, 32'd0);
         chk("result_held", result, e.r);
      end
   endtask

   initial begin
      int   ndone;
      vec_t v;
      vt[0]  = mk(ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1, 5);
      vt[1]  = mk(ALU_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 1, 1, 0, 5);
      vt[2]  = mk(ALU_SUB, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 0, 0, 0, 5);
      vt[3]  = mk(ALU_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0, 0, 6);
      vt[4]  = mk(ALU_SLT, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1, 0, 0, 6);
      vt[5]  = mk(ALU_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 0, 0, 0, 5);
      vt[6]  = mk(ALU_OR,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 0, 0, 0, 5);
      vt[7]  = mk(ALU_NOR, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 0, 0, 0, 5);
      vt[8]  = mk(ALU_NOR, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h000F000F, 0, 0, 0, 5);
      vt[9]  = mk(4'b1111, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0, 0, 0, 5);
      vt[10] = mk(ALU_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 1, 0, 5);
      vt[11] = mk(ALU_SLT, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 0, 0, 0, 6);
      vt[12] = mk(ALU_ADD, 32'h00FF00FF, 32'h00010001, 32'h01000100, 0, 0, 0, 5);
      for (int i = 13; i < 18; i++) begin
         case ($urandom_range(0, 4))
            0: v = model(ALU_ADD, $urandom, $urandom);
            1: v = model(ALU_SUB, $urandom, $urandom);
            2: v = model(ALU_SLT, $urandom, $urandom);
            3: v = model(ALU_OR, $urandom, $urandom);
            default: v = model(ALU_NOR, $urandom, $urandom);
         endcase
         vt[i] = v;
      end

      #1;
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk("reset_done", {31'b0, done}, 32'd0);
      chk("reset_result", result, 32'd0);
      chk("reset_flags", {29'b0, zero, cout, overflow}, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;

      for (int i = 0; i < 18; i++) do_op(vt[i], 1'b0);

      // Extra starts while busy are dropped; next request follows immediately.
      do_op(model(ALU_ADD, 32'h12345678, 32'h11111111), 1'b1);
      do_op(model(ALU_SUB, 32'h00000010, 32'h00000003), 1'b0);

      // Reset at cycle 3 of a SUB aborts with everything cleared.
      do_op(model(ALU_ADD, 32'h0000000F, 32'h80000000), 1'b0);
      @(negedge clk);
      ALU_control = ALU_SUB; src1 = 32'h9; src2 = 32'h3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_done", {31'b0, done}, 32'd0);
      chk("abort_result", result, 32'd0);
      chk("abort_flags", {29'b0, zero, cout, overflow}, 32'd0);
      ndone = 0;
      repeat (2) begin @(posedge clk); #1; if (done) ndone++; end
      @(negedge clk); rst_n = 1'b1;
      repeat (6) begin @(posedge clk); #1; if (done) ndone++; end
      chk("abort_no_done", ndone, 0);
      do_op(model(ALU_ADD, 32'hDEADBEEF, 32'h01010101), 1'b0);

      chk("scoreboard_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
